// File: rtl/md5_search_pkg.sv
// Shared state encoding and lane-vector helpers for the MD5 search scheduler.
package md5_search_pkg;

    localparam int MAX_LANES = 16;

    localparam logic [4:0] ST_IDLE   = 5'b00001;
    localparam logic [4:0] ST_RUN    = 5'b00010;
    localparam logic [4:0] ST_PAUSED = 5'b00100;
    localparam logic [4:0] ST_DRAIN  = 5'b01000;
    localparam logic [4:0] ST_DONE   = 5'b10000;

    function automatic logic [4:0] popcount_lanes(input logic [MAX_LANES-1:0] m);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_LANES; i++) c = c + {4'd0, m[i]};
        return c;
    endfunction

    // Returns {hit, index} of the lowest set bit.
    function automatic logic [4:0] first_lane(input logic [MAX_LANES-1:0] m);
        logic [4:0] r;
        r = '0;
        for (int i = MAX_LANES - 1; i >= 0; i--) if (m[i]) r = {1'b1, 4'(i)};
        return r;
    endfunction

endpackage

// File: rtl/search_tag_delay.sv
// Tag delay line mirroring the pipeline latency: carries {mask, base} of each issue.
module search_tag_delay #(
    parameter int LANES  = 2,
    parameter int CAND_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic [LANES-1:0]  mask_i,
    input  logic [CAND_W-1:0] base_i,
    output logic [LANES-1:0]  mask_o,
    output logic [CAND_W-1:0] base_o
);

    logic [LANES-1:0]  mask_q [DEPTH];
    logic [CAND_W-1:0] base_q [DEPTH];

    // Only the valid field is reset; stale bases are harmless behind a zero mask.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mask_q[i] <= '0;
        end else begin
            mask_q[0] <= clr_i ? '0 : mask_i;
            for (int i = 1; i < DEPTH; i++) mask_q[i] <= clr_i ? '0 : mask_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        base_q[0] <= base_i;
        for (int i = 1; i < DEPTH; i++) base_q[i] <= base_q[i-1];
    end

    assign mask_o = mask_q[DEPTH-1];
    assign base_o = base_q[DEPTH-1];

endmodule

// File: rtl/md5_search_scheduler.sv
// Issues candidate groups to LANES MD5 pipelines over an inclusive range and resolves matches.
module md5_search_scheduler
    import md5_search_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int LANE_BITS    = (LANES > 1) ? $clog2(LANES) : 1,
    parameter int CAND_W       = 32,
    parameter int PIPE_LATENCY = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              pause_i,
    input  logic [CAND_W-1:0] range_start_i,
    input  logic [CAND_W-1:0] range_end_i,
    input  logic [LANES-1:0]  lane_found_i,
    output logic [CAND_W-1:0] cand_base_o,
    output logic [LANES-1:0]  cand_mask_o,
    output logic              busy_o,
    output logic              paused_o,
    output logic              done_o,
    output logic              found_o,
    output logic [CAND_W-1:0] found_value_o,
    output logic              range_error_o,
    output logic [CAND_W:0]   tested_count_o
);

    localparam int CNT_W = $clog2(PIPE_LATENCY + 1);

    logic [4:0]           state_q, state_d;
    logic [CAND_W-1:0]    base_q, base_d, end_q, end_d, fval_q, fval_d;
    logic                 found_q, found_d, rerr_q, rerr_d;
    logic [CAND_W:0]      tested_q, tested_d;
    logic [CNT_W-1:0]     infl_q, infl_d, infl_nxt;
    logic [LANES-1:0]     grp_mask, issue_mask, ret_mask, qual, keep;
    logic [CAND_W-1:0]    ret_base;
    logic [MAX_LANES-1:0] qual_x, cnt_x;
    logic [4:0]           fl;
    logic [LANE_BITS-1:0] hit_lane;
    logic                 busy, last_grp, match, issue, go_idle, dly_clr;

    assign busy = (state_q == ST_RUN) || (state_q == ST_PAUSED) || (state_q == ST_DRAIN);

    // Range comparisons are done one bit wider so a range ending at all-ones terminates.
    always_comb begin
        for (int i = 0; i < LANES; i++)
            grp_mask[i] = ({1'b0, base_q} + (CAND_W+1)'(i)) <= {1'b0, end_q};
    end
    assign last_grp = ({1'b0, base_q} + (CAND_W+1)'(LANES - 1)) >= {1'b0, end_q};

    assign qual = lane_found_i & ret_mask;
    always_comb begin
        qual_x = '0;
        qual_x[LANES-1:0] = qual;
    end
    assign fl       = first_lane(qual_x);
    assign hit_lane = LANE_BITS'(fl[3:0]);
    assign match    = busy && enable_i && fl[4];

    // On the match cycle only lanes up to and including the winner are retired.
    always_comb begin
        for (int i = 0; i < LANES; i++)
            keep[i] = !match || (LANE_BITS'(i) <= hit_lane);
        cnt_x = '0;
        cnt_x[LANES-1:0] = ret_mask & keep;
    end

    assign issue      = (state_q == ST_RUN) && enable_i && !pause_i && !match;
    assign issue_mask = issue ? grp_mask : '0;
    assign infl_nxt   = infl_q + CNT_W'(|issue_mask) - CNT_W'(|ret_mask);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        end_d    = end_q;
        fval_d   = fval_q;
        found_d  = found_q;
        rerr_d   = rerr_q;
        infl_d   = infl_nxt;
        tested_d = busy ? tested_q + (CAND_W+1)'(popcount_lanes(cnt_x)) : tested_q;
        go_idle  = 1'b0;
        case (state_q)
            ST_IDLE: if (enable_i) begin
                end_d  = range_end_i;
                base_d = range_start_i;
                if (range_start_i > range_end_i) begin
                    state_d = ST_DONE;
                    rerr_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_PAUSED, ST_DRAIN: begin
                if (!enable_i) begin
                    go_idle = 1'b1;
                end else if (match) begin
                    state_d = ST_DONE;
                    found_d = 1'b1;
                    fval_d  = ret_base + CAND_W'(hit_lane);
                end else if (state_q == ST_RUN) begin
                    if (pause_i)       state_d = ST_PAUSED;
                    else if (last_grp) state_d = ST_DRAIN;
                    else               base_d  = base_q + CAND_W'(LANES);
                end else if (state_q == ST_PAUSED) begin
                    if (!pause_i) state_d = ST_RUN;
                end else if (infl_nxt == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (!enable_i) go_idle = 1'b1;
            default: go_idle = 1'b1;
        endcase
        if (go_idle) begin
            state_d  = ST_IDLE;
            base_d   = '0;
            end_d    = '0;
            fval_d   = '0;
            found_d  = 1'b0;
            rerr_d   = 1'b0;
            tested_d = '0;
            infl_d   = '0;
        end
    end

    assign dly_clr = go_idle;

    search_tag_delay #(
        .LANES  (LANES),
        .CAND_W (CAND_W),
        .DEPTH  (PIPE_LATENCY)
    ) u_tag_delay (
        .clk_i  (clk_i),
        .rst_i  (reset_i),
        .clr_i  (dly_clr),
        .mask_i (issue_mask),
        .base_i (base_q),
        .mask_o (ret_mask),
        .base_o (ret_base)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            end_q    <= '0;
            fval_q   <= '0;
            found_q  <= 1'b0;
            rerr_q   <= 1'b0;
            tested_q <= '0;
            infl_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            end_q    <= end_d;
            fval_q   <= fval_d;
            found_q  <= found_d;
            rerr_q   <= rerr_d;
            tested_q <= tested_d;
            infl_q   <= infl_d;
        end
    end

    assign cand_base_o    = base_q;
    assign cand_mask_o    = issue_mask;
    assign busy_o         = busy;
    assign paused_o       = (state_q == ST_PAUSED);
    assign done_o         = (state_q == ST_DONE);
    assign found_o        = found_q;
    assign found_value_o  = fval_q;
    assign range_error_o  = rerr_q;
    assign tested_count_o = tested_q;

endmodule

// File: tb/tb_md5_search_scheduler.sv
// Directed bench for md5_search_scheduler with LANES=2, PIPE_LATENCY=4.
module tb_md5_search_scheduler;

    logic        clk = 1'b0;
    logic        rst, en, pause;
    logic [31:0] rs, re;
    logic [1:0]  lf;
    logic [31:0] cand_base, found_value;
    logic [1:0]  cand_mask;
    logic        busy, paused, done, found, range_error;
    logic [32:0] tested;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    md5_search_scheduler #(
        .LANES        (2),
        .CAND_W       (32),
        .PIPE_LATENCY (4)
    ) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .enable_i       (en),
        .pause_i        (pause),
        .range_start_i  (rs),
        .range_end_i    (re),
        .lane_found_i   (lf),
        .cand_base_o    (cand_base),
        .cand_mask_o    (cand_mask),
        .busy_o         (busy),
        .paused_o       (paused),
        .done_o         (done),
        .found_o        (found),
        .found_value_o  (found_value),
        .range_error_o  (range_error),
        .tested_count_o (tested)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; en = 0; pause = 0; rs = 0; re = 0; lf = 0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_fval", found_value, 0);
        chk("rst_rerr", range_error, 0);
        chk("rst_tested", tested, 0);
        chk("rst_base", cand_base, 0);
        chk("rst_mask", cand_mask, 0);
        chk("rst_paused", paused, 0);
        tick(); rst = 0;
        tick();

        // Range 0..9, no match
        rs = 0; re = 9; en = 1; #1;
        chk("t1_idle_mask", cand_mask, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_base", cand_base, 2 * i);
            chk("t1_mask", cand_mask, 2'b11);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_drain_busy", busy, 1);
            chk("t1_drain_mask", cand_mask, 0);
        end
        tick();
        chk("t1_done", done, 1);
        chk("t1_found", found, 0);
        chk("t1_tested", tested, 10);
        chk("t1_busy", busy, 0);
        en = 0; tick();
        chk("t1_idle_done", done, 0);
        chk("t1_idle_tested", tested, 0);

        // Range 3..7, partial last group
        rs = 3; re = 7; en = 1;
        tick(); chk("t2_b0", cand_base, 3); chk("t2_m0", cand_mask, 2'b11);
        tick(); chk("t2_b1", cand_base, 5); chk("t2_m1", cand_mask, 2'b11);
        tick(); chk("t2_b2", cand_base, 7); chk("t2_m2", cand_mask, 2'b01);
        wait_done("t2_done", 10);
        chk("t2_tested", tested, 5);
        chk("t2_found", found, 0);
        en = 0; tick();

        // Range 0..99, lane 1 hits when base 40 retires
        rs = 0; re = 99; en = 1;
        for (int i = 0; i < 25; i++) tick();
        chk("t3_base48", cand_base, 48);
        lf = 2'b10; #1;
        chk("t3_match_mask", cand_mask, 0);
        tick(); lf = 0;
        chk("t3_found", found, 1);
        chk("t3_fval", found_value, 41);
        chk("t3_tested", tested, 42);
        chk("t3_done", done, 1);
        tick();
        chk("t3_no_issue_mask", cand_mask, 0);
        chk("t3_no_issue_base", cand_base, 48);
        en = 0; tick();

        // Pause mid-run, then match retiring while paused
        rs = 0; re = 99; en = 1;
        for (int i = 0; i < 11; i++) tick();
        chk("t4_base20", cand_base, 20);
        pause = 1; #1;
        chk("t4_pause_mask", cand_mask, 0);
        tick(); chk("t4_paused1", paused, 1); chk("t4_p1_mask", cand_mask, 0);
        tick(); chk("t4_paused2", paused, 1); chk("t4_p2_tested", tested, 16);
        tick(); pause = 0; #1;
        chk("t4_p3_paused", paused, 1); chk("t4_p3_mask", cand_mask, 0);
        tick(); chk("t4_res_base", cand_base, 20); chk("t4_res_mask", cand_mask, 2'b11);
        chk("t4_res_paused", paused, 0);
        tick(); chk("t4_res_base2", cand_base, 22); chk("t4_res_mask2", cand_mask, 2'b11);
        tick(); pause = 1; #1;
        chk("t4_pause2_base", cand_base, 24); chk("t4_pause2_mask", cand_mask, 0);
        tick(); tick(); tick();
        lf = 2'b11; #1;
        chk("t4_s3_paused", paused, 1);
        tick(); lf = 0; pause = 0;
        chk("t4_found", found, 1);
        chk("t4_fval", found_value, 22);
        chk("t4_tested", tested, 23);
        chk("t4_done", done, 1);
        chk("t4_base_held", cand_base, 24);
        en = 0; tick();

        // Top-of-range, no wrap
        rs = 32'hFFFF_FFFC; re = 32'hFFFF_FFFF; en = 1;
        tick(); chk("t5_b0", cand_base, 32'hFFFF_FFFC); chk("t5_m0", cand_mask, 2'b11);
        tick(); chk("t5_b1", cand_base, 32'hFFFF_FFFE); chk("t5_m1", cand_mask, 2'b11);
        tick(); chk("t5_drain_busy", busy, 1); chk("t5_drain_mask", cand_mask, 0);
        wait_done("t5_done", 10);
        chk("t5_tested", tested, 4);
        chk("t5_found", found, 0);
        en = 0; tick();

        // Inverted range
        rs = 10; re = 5; en = 1;
        tick();
        chk("t6_done", done, 1);
        chk("t6_rerr", range_error, 1);
        chk("t6_busy", busy, 0);
        chk("t6_mask", cand_mask, 0);
        en = 0; tick();
        chk("t6_clr_rerr", range_error, 0);
        chk("t6_clr_done", done, 0);

        // Abort mid-run, stale result after re-enable
        rs = 0; re = 99; en = 1;
        for (int i = 0; i < 7; i++) tick();
        chk("t7_tested_pre", tested, 4);
        en = 0; #1;
        chk("t7_abort_mask", cand_mask, 0);
        tick();
        chk("t7_abort_busy", busy, 0);
        chk("t7_abort_done", done, 0);
        chk("t7_abort_tested", tested, 0);
        chk("t7_abort_base", cand_base, 0);
        en = 1;
        tick(); lf = 2'b11; #1;
        chk("t7_re_mask", cand_mask, 2'b11);
        chk("t7_re_base", cand_base, 0);
        tick(); lf = 0;
        chk("t7_stale_found", found, 0);
        chk("t7_stale_busy", busy, 1);
        chk("t7_stale_base", cand_base, 2);
        en = 0; tick();

        // Reset pulsed in DRAIN
        rs = 0; re = 3; en = 1;
        tick(); tick(); tick();
        chk("t8_drain_busy", busy, 1);
        rst = 1; #1;
        chk("t8_rst_busy", busy, 0);
        chk("t8_rst_done", done, 0);
        chk("t8_rst_found", found, 0);
        chk("t8_rst_base", cand_base, 0);
        chk("t8_rst_mask", cand_mask, 0);
        chk("t8_rst_tested", tested, 0);
        en = 0; tick(); rst = 0; tick();

        // Recovery run
        rs = 4; re = 5; en = 1;
        tick(); chk("t9_base", cand_base, 4); chk("t9_mask", cand_mask, 2'b11);
        wait_done("t9_done", 10);
        chk("t9_tested", tested, 2);
        chk("t9_found", found, 0);
        en = 0; tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/md5_search_scheduler.md
Name: md5_search_scheduler

Overview:
- Parametrised successor of the MD5 brute-force driver: issues candidate groups to LANES parallel MD5 pipelines over a programmable inclusive range [range_start, range_end].
- Tracks in-flight candidates with a tag delay line, so pause/resume and the drain at range end are exact. A match is reported with the precise candidate value.
- Sits between the AXI register block (control, range, status) and the pipeline array. Pipelines are instantiated outside this block.

Parameters:
- LANES, 2, number of pipelines; power of two, 1..16
- LANE_BITS, $clog2(LANES) (min 1), lane index width
- CAND_W, 32, candidate width
- PIPE_LATENCY, 64, cycles from candidate issue to the lane_found sample for that candidate; >=1

Ports:
- CLK  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; 1=search, 0=abort/return to IDLE
- pause  in  1  level; holds issue while 1
- range_start  in  CAND_W  first candidate, sampled on IDLE->RUN
- range_end  in  CAND_W  last candidate (inclusive), sampled on IDLE->RUN
- lane_found  in  LANES  per-lane match, aligned PIPE_LATENCY after issue
- cand_base  out  CAND_W  lane i hashes cand_base+i
- cand_mask  out  LANES  per-lane valid for the current issue
- busy  out  1  state in RUN/PAUSED/DRAIN
- paused  out  1  state==PAUSED
- done  out  1  state==DONE
- found  out  1  match latched
- found_value  out  CAND_W  matching candidate
- range_error  out  1  range_start>range_end at start
- tested_count  out  CAND_W+1  candidates retired (valid lanes only)

Behaviour:
- Reset (async): state=IDLE; all outputs 0; delay line valid bits cleared.
- States: IDLE, RUN, PAUSED, DRAIN, DONE. Encoding is one-hot.
- IDLE: cand_mask=0. On enable=1, latch the range.
  - If start>end: go to DONE, range_error=1.
  - Otherwise: go to RUN, base=range_start.
- RUN: each cycle, issue cand_base=base with cand_mask bit i = (base+i <= range_end), computed in CAND_W+1 bits so no wrap; then base += LANES.
  - Last group: base+LANES-1 >= range_end, computed in CAND_W+1 bits. The last group may be partial. After it issues, go to DRAIN.
  - pause=1: go to PAUSED. The pause cycle itself issues nothing (mask=0).
- PAUSED: mask=0. The delay line keeps shifting, so in-flight results still retire and a match is still accepted. pause=0 returns to RUN and resumes at the held base.
- DRAIN: mask=0. Wait until the in-flight counter is 0, then go to DONE with found=0.
- Delay line: PIPE_LATENCY-deep shift register of {mask, base}. It shifts every cycle in every state, and idle cycles enter as mask=0. A lane_found bit counts only if the retiring mask bit is set.
- In-flight counter: +1 for an issue with a nonzero mask, -1 for a retire with a nonzero mask; the same cycle does both.
- Match (RUN/PAUSED/DRAIN): pick the lowest-index qualified lane k.
  - found=1, found_value = retiring base + k.
  - Go to DONE. Issue stops that cycle; later retires are ignored.
- tested_count: adds popcount(retiring mask) each cycle while busy. On the match cycle it adds only lanes 0..k.
- DONE: done=1; found, found_value and range_error hold. enable=0 returns to IDLE.
  - IDLE entry clears found/done/range_error/tested_count, the delay line valids and the in-flight count.
- enable=0 in RUN/PAUSED/DRAIN: abort to IDLE on the next edge (same clears as IDLE entry); done stays 0.
- Priority within a cycle: reset > enable=0 > match > range-end/pause.
- Overflow: range_end=2^CAND_W-1 must terminate. The last-group test uses the extended width, so base never wraps to 0.
- LANES=1: lane index is 0; LANE_BITS is forced to 1 with the MSB unused.

Decomposition:
- Package md5_search_pkg holds:
  - the state enum
  - the function popcount_lanes
  - the function first_lane(mask) returning {hit, index}
- Sub-module search_tag_delay: parametrised shift register (width LANES+CAND_W, depth PIPE_LATENCY, async reset clears the valid field only).
- The top holds the FSM, the issue counter, the in-flight counter and match resolution.

Test Plan:
- LANES=2, PIPE_LATENCY=4, range 0..9, no match -> 5 issues of mask 2'b11; DRAIN 4 cycles; done=1, found=0, tested_count=10.
- Range 3..7, LANES=4 -> bases 3,7, masks 4'b1111 then 4'b0001; tested_count=5.
- Range 0..99, lane_found[1] asserted when base 40 retires -> found_value=41, tested_count=42, no later issues.
- Pause asserted 3 cycles mid-run, with a match on a group issued before the pause and retiring during PAUSED -> found is accepted; the cand_base sequence resumes without a gap or duplicate.
- Range FFFFFFFC..FFFFFFFF, LANES=2 -> 2 issues, no wrap, done with tested_count=4. Range 10..5 -> DONE next cycle, range_error=1.
- enable dropped mid-RUN, then reset pulsed in DRAIN -> IDLE with all outputs 0; a stale lane_found after re-enable is ignored.
